gate_nand_pipe: RTL and testbench
=================================

// Module: gate_nand_pipe
// PURPOSE
//   Pipelined, flow-controlled multi-way NAND: WIRE independent lanes, each lane the NAND of WAY inputs.
//   Registered successor of the combinational gate_nand, for wide-fan-in reductions on timing-critical paths.
//   Sits between producer/consumer stages with valid/ready on both sides; fully stallable, no data loss.
// PARAMETERS
//   BEHAVIORAL  1  1: reduction written with operators; 0: reduction levels built from structural gate_and/gate_nand
//   WAY         4  inputs per lane, >=2
//   WIRE        8  lanes (output bits), >=1
//   STAGES      2  pipeline register stages = latency in cycles; 1 <= STAGES <= clog2(WAY)+1
// PORTS
//   clk        in   1         single clock, rising edge
//   reset      in   1         synchronous, active-high
//   in         in   WAY*WIRE  group k = in[k*WIRE +: WIRE]; lane w uses bit w of every group
//   in_valid   in   1         producer has a word on `in`
//   in_ready   out  1         block accepts word this cycle
//   out        out  WIRE      out[w] = ~&{in[k*WIRE+w] : k=0..WAY-1} of the accepted word
//   out_valid  out  1         `out` holds a result
//   out_ready  in   1         consumer takes result this cycle
//   xfer_cnt   out  16        completed output transfers (only with GATE_NAND_PIPE_CNT_EN)
// BEHAVIOUR
//   - Clock and reset: one clock; reset is synchronous and active-high.
//   - Accept: in_valid & in_ready at a rising edge. Deliver: out_valid & out_ready at a rising edge.
//   - Stages: STAGES register stages, each with its own valid bit v[s].
//     - Stage 0 captures `in` or a first partial AND level.
//     - The AND tree (clog2(WAY) levels) is distributed across the stages; the final inversion happens in the last stage.
//     - The split is implementation-defined; function and latency are not.
//   - Latency: an accepted word gives out_valid exactly STAGES cycles later, provided no stall occurred.
//     - Example: accept at edge N, out_valid high after edge N+STAGES-1, output ready to deliver at edge N+STAGES.
//   - Advance rule: adv[s] = v[s] & (s==last ? out_ready : (~v[s+1] | adv[s+1])).
//     - Stage s loads from s-1 when ~v[s] | adv[s].
//     - in_ready = ~v[0] | adv[0]. This is combinational from out_ready; there is no skid buffer.
//     - Bubbles collapse, so the pipeline holds STAGES words max.
//   - Throughput: with out_ready held high, one word per cycle sustained, no bubbles inserted.
//   - Stall: out_ready=0 with the pipe full gives in_ready=0 the same cycle.
//     - out and all stage data stay stable while out_valid=1 and out_ready=0.
//   - Simultaneous accept and deliver when full: legal. Occupancy is unchanged, no word is dropped or duplicated.
//   - in_valid=0 cycles: bubbles propagate. out_valid drops when the last word drains.
//   - Reset: all v[s]=0, out_valid=0, out=0, xfer_cnt=0, in_ready=1 from the first cycle after reset deasserts.
//     - Reset mid-operation discards all in-flight words; no output is produced for them.
//     - in_ready=0 while reset is high.
//   - Data registers need no reset except the last stage, which must drive out=0 after reset.
//   - Odd WAY: missing tree leaves are padded with 1 (AND identity). WAY=2 is a plain 2-input NAND per lane.
//   - out is X-free whenever out_valid=1 and inputs were known at accept.
// CONFIGURATION
//   GATE_NAND_PIPE_CNT_EN defined:
//     - xfer_cnt increments by 1 on each delivery (out_valid & out_ready).
//     - Saturates at 16'hFFFF and does not wrap.
//     - Cleared by reset.
//   GATE_NAND_PIPE_CNT_EN undefined:
//     - xfer_cnt port still present, tied to 16'h0000.
//     - No counter logic is synthesised.
// TESTING (default WAY=4, WIRE=8, STAGES=2 unless noted)
//   1. in={8'hFF,8'hFF,8'hFF,8'hFF} accepted at edge 0, out_ready=1:
//      out_valid=1 after edge 1, out=8'h00 delivered at edge 2.
//   2. Back-to-back words {FF,FF,FF,0F}, {F0,FF,FF,FF}, {00,00,00,00}, one per cycle, out_ready=1:
//      outputs F0, 0F, FF on consecutive cycles with no bubbles.
//   3. Fill the pipe, hold out_ready=0 for 5 cycles:
//      in_ready=0 once 2 words are held; out stable; release delivers both words in order, none lost.
//   4. Assert reset with 2 words in flight:
//      next cycle out_valid=0, out=0, in_ready=1 after deassert; discarded words never appear.
//   5. WAY=3, WIRE=1, STAGES=1, all 8 input combinations:
//      out=0 only for 3'b111; latency 1 cycle. Repeat both tests with BEHAVIORAL=0 and compare bit-exact.
//   6. With GATE_NAND_PIPE_CNT_EN, 70000 deliveries:
//      xfer_cnt=16'hFFFF and stays there; without the macro it stays 0.
//      Random valid/ready stress against a scoreboard model shows no mismatch.

Source files
------------

// File: rtl/gate_nand_pipe.sv
// gate_nand_pipe: pipelined, valid/ready flow-controlled multi-way NAND.
// WIRE lanes; lane w is the NAND of bit w of each of the WAY input groups.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in[WAY*WIRE]         group k = in[k*WIRE +: WIRE]
//   in_valid / in_ready  producer handshake (accept on both high)
//   out[WIRE]            NAND result of the word in the last stage
//   out_valid/out_ready  consumer handshake (deliver on both high)
//   xfer_cnt[16]         saturating delivery count; tied to 0 unless
//                        GATE_NAND_PIPE_CNT_EN is defined
//
// Parameters: BEHAVIORAL (1 = operators, 0 = gate_and/gate_nand cells),
//   WAY >= 2, WIRE >= 1, 1 <= STAGES <= clog2(WAY)+1.

module gate_and #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

module gate_nand #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a & b);
endmodule

module gate_nand_pipe #(
    parameter int BEHAVIORAL = 1,
    parameter int WAY        = 4,
    parameter int WIRE       = 8,
    parameter int STAGES     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WAY*WIRE-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIRE-1:0]     out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         xfer_cnt
);

    localparam int LVLS   = $clog2(WAY);
    localparam int LEAVES = 1 << LVLS;
    localparam int NODES  = 2 * LEAVES;
    localparam int LAST   = STAGES - 1;
    // Stage s < LAST registers tree level FIRST_REG + s; all the
    // remaining levels are front-loaded into the first stage.
    localparam int FIRST_REG = LVLS - LAST;

    // ------------------------------------------------------------
    // Valid / advance chain
    // ------------------------------------------------------------
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] dl;

    // Walk from the output back to the input: a stage may move when
    // the stage ahead is empty or is itself moving this cycle.
    always_comb begin
        logic room;
        adv  = '0;
        ld   = '0;
        room = out_ready;
        for (int s = LAST; s >= 0; s--) begin
            adv[s] = v[s] & room;
            ld[s]  = ~v[s] | adv[s];
            room   = ld[s];
        end
    end

    if (STAGES == 1) begin : g_src1
        assign v_src = in_valid;
    end else begin : g_srcn
        assign v_src = {v[STAGES-2:0], in_valid};
    end

    // Data registers only load when a real word arrives, so a held
    // word is never overwritten by a bubble.
    assign dl = ld & v_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ld[s]) begin
                    v[s] <= v_src[s];
                end
            end
        end
    end

    assign in_ready  = ld[0] & ~reset;
    assign out_valid = v[LAST];

    // ------------------------------------------------------------
    // AND tree, heap indexed: node 1 is the root, leaves live at
    // LEAVES .. 2*LEAVES-1. c_* is the combinational value of a node,
    // f_* is what its parent sees (registered or pass-through).
    // ------------------------------------------------------------
    logic [WIRE-1:0] c_node [2:NODES-1];
    logic [WIRE-1:0] f_node [2:NODES-1];

    for (genvar i = 2; i < NODES; i++) begin : g_node
        localparam int DEPTH = $clog2(i + 1) - 1;
        localparam int LVL   = LVLS - DEPTH;

        if (i >= LEAVES) begin : g_leaf
            localparam int K = i - LEAVES;
            if (K < WAY) begin : g_in
                assign c_node[i] = in[K*WIRE +: WIRE];
            end else begin : g_pad
                // Missing leaves take the AND identity.
                assign c_node[i] = '1;
            end
        end else begin : g_inner
            if (BEHAVIORAL != 0) begin : g_beh
                assign c_node[i] = f_node[2*i] & f_node[2*i+1];
            end else begin : g_str
                gate_and #(
                    .WIDTH (WIRE)
                ) u_and (
                    .a (f_node[2*i]),
                    .b (f_node[2*i+1]),
                    .y (c_node[i])
                );
            end
        end

        if (LVL >= FIRST_REG) begin : g_reg
            localparam int S = LVL - FIRST_REG;
            logic [WIRE-1:0] q;
            always_ff @(posedge clk) begin
                if (dl[S]) begin
                    q <= c_node[i];
                end
            end
            assign f_node[i] = q;
        end else begin : g_comb
            assign f_node[i] = c_node[i];
        end
    end

    // ------------------------------------------------------------
    // Root: last AND level fused with the inversion, last stage.
    // ------------------------------------------------------------
    logic [WIRE-1:0] root_n;
    logic [WIRE-1:0] out_q;

    if (BEHAVIORAL != 0) begin : g_root_beh
        assign root_n = ~(f_node[2] & f_node[3]);
    end else begin : g_root_str
        gate_nand #(
            .WIDTH (WIRE)
        ) u_nand (
            .a (f_node[2]),
            .b (f_node[3]),
            .y (root_n)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else if (dl[LAST]) begin
            out_q <= root_n;
        end
    end

    assign out = out_q;

    // ------------------------------------------------------------
    // Delivery counter
    // ------------------------------------------------------------
`ifdef GATE_NAND_PIPE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (adv[LAST] && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gate_nand_pipe.sv
// tb_gate_nand_pipe: directed and random checks of gate_nand_pipe
// against a queue-based behavioural model, plus a WAY=3 corner build.

module tb_gate_nand_pipe;

    localparam int WAY    = 4;
    localparam int WIRE   = 8;
    localparam int STAGES = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in;
    logic        in_valid;
    logic        out_ready;
    wire         in_ready, out_valid;
    wire  [7:0]  out;
    wire  [15:0] xfer_cnt;

    wire         s_in_ready, s_out_valid;
    wire  [7:0]  s_out;
    wire  [15:0] s_xfer;

    logic [2:0]  t_in;
    logic        t_valid;
    wire         tb_rdy, tb_ov, tb_out;
    wire         ts_rdy, ts_ov, ts_out;
    wire  [15:0] tb_cnt, ts_cnt;

    gate_nand_pipe #(
        .BEHAVIORAL (1), .WAY (WAY), .WIRE (WIRE), .STAGES (STAGES)
    ) dut (
        .clk (clk), .reset (reset), .in (in), .in_valid (in_valid),
        .in_ready (in_ready), .out (out), .out_valid (out_valid),
        .out_ready (out_ready), .xfer_cnt (xfer_cnt)
    );

    gate_nand_pipe #(
        .BEHAVIORAL (0), .WAY (WAY), .WIRE (WIRE), .STAGES (STAGES)
    ) dut_s (
        .clk (clk), .reset (reset), .in (in), .in_valid (in_valid),
        .in_ready (s_in_ready), .out (s_out), .out_valid (s_out_valid),
        .out_ready (out_ready), .xfer_cnt (s_xfer)
    );

    gate_nand_pipe #(
        .BEHAVIORAL (1), .WAY (3), .WIRE (1), .STAGES (1)
    ) dut_t3b (
        .clk (clk), .reset (reset), .in (t_in), .in_valid (t_valid),
        .in_ready (tb_rdy), .out (tb_out), .out_valid (tb_ov),
        .out_ready (1'b1), .xfer_cnt (tb_cnt)
    );

    gate_nand_pipe #(
        .BEHAVIORAL (0), .WAY (3), .WIRE (1), .STAGES (1)
    ) dut_t3s (
        .clk (clk), .reset (reset), .in (t_in), .in_valid (t_valid),
        .in_ready (ts_rdy), .out (ts_out), .out_valid (ts_ov),
        .out_ready (1'b1), .xfer_cnt (ts_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference NAND, straight from the lane/group definition.
    function automatic logic [7:0] nand_ref(input logic [31:0] x);
        logic [7:0] r;
        for (int w = 0; w < WIRE; w++) begin
            r[w] = 1'b1;
            for (int k = 0; k < WAY; k++) r[w] = r[w] & x[k*WIRE+w];
        end
        return ~r;
    endfunction

    // Model: FIFO of accepted words. A word is at the output once it
    // has spent STAGES-1 edges in the pipe and its predecessor left.
    typedef struct {
        logic [7:0] d;
        int         acc;
    } ent_t;

    ent_t        q[$];
    int          cyc      = 0;
    int          last_del = 0;
    logic [15:0] m_cnt    = 16'h0000;
    bit          mon_en   = 1'b0;

    always @(negedge clk) begin
        bit e_ov, e_ir, acc, del;
        e_ov = (q.size() > 0) && (cyc >= q[0].acc + STAGES - 1)
               && (cyc >= last_del);
        e_ir = !reset && ((q.size() < STAGES) || out_ready);
        if (mon_en) begin
            chk("out_valid", out_valid, e_ov);
            chk("in_ready", in_ready, e_ir);
            chk("xfer_cnt", xfer_cnt, m_cnt);
            chk("s_out_valid", s_out_valid, e_ov);
            chk("s_in_ready", s_in_ready, e_ir);
            chk("s_xfer_cnt", s_xfer, m_cnt);
            if (e_ov) begin
                chk("out", out, q[0].d);
                chk("s_out", s_out, q[0].d);
            end
        end
        acc = e_ir && in_valid;
        del = e_ov && out_ready;
        cyc++;
        if (reset) begin
            q.delete();
            m_cnt    = 16'h0000;
            last_del = cyc;
        end else begin
            if (del) begin
                void'(q.pop_front());
                last_del = cyc;
`ifdef GATE_NAND_PIPE_CNT_EN
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end
            if (acc) q.push_back('{nand_ref(in), cyc});
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  t_exp;
        logic [15:0] cnt_exp;
        t_exp = 8'b0111_1111;
`ifdef GATE_NAND_PIPE_CNT_EN
        cnt_exp = 16'hFFFF;
`else
        cnt_exp = 16'h0000;
`endif
        reset = 1'b1; in = '0; in_valid = 1'b0; out_ready = 1'b0;
        t_in = '0; t_valid = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 8'h00);
        chk("rst_xfer", xfer_cnt, 16'h0);

        // 1: all ones -> 00, latency 2
        in = {4{8'hFF}}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_out", out, 8'h00);
        step();
        chk("t1_drain", out_valid, 0);

        // 2: back-to-back, no bubbles
        in = {8'hFF, 8'hFF, 8'hFF, 8'h0F}; in_valid = 1'b1;
        step();
        in = {8'hF0, 8'hFF, 8'hFF, 8'hFF};
        step();
        chk("t2_out0", out, 8'hF0);
        in = {4{8'h00}};
        step();
        chk("t2_out1", out, 8'h0F);
        in_valid = 1'b0;
        step();
        chk("t2_out2", out, 8'hFF);
        chk("t2_valid2", out_valid, 1);
        step();
        chk("t2_drain", out_valid, 0);

        // 3: fill, stall 5 cycles, release
        out_ready = 1'b0;
        in = {4{8'hAA}}; in_valid = 1'b1;
        step();
        in = {8'hFF, 8'hFF, 8'h3C, 8'hFF};
        step();
        in = {4{8'h00}};
        for (int i = 0; i < 5; i++) begin
            chk("t3_in_ready", in_ready, 0);
            chk("t3_valid", out_valid, 1);
            chk("t3_hold", out, 8'h55);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_rel_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_out_b", out, 8'hC3);
        step();
        chk("t3_out_c", out, 8'hFF);
        step();
        chk("t3_drain", out_valid, 0);

        // 4: reset with two words in flight
        out_ready = 1'b0;
        in = {4{8'h12}}; in_valid = 1'b1;
        step();
        in = {4{8'h34}};
        step();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t4_rst_ready", in_ready, 0);
        step();
        reset = 1'b0;
        #1;
        chk("t4_valid", out_valid, 0);
        chk("t4_out", out, 8'h00);
        chk("t4_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_gone", out_valid, 0);
        end

        // 5: WAY=3 WIRE=1 STAGES=1, both implementations
        t_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            t_in = c[2:0];
            step();
            chk("t5_b_valid", tb_ov, 1);
            chk("t5_b_out", tb_out, t_exp[c]);
            chk("t5_s_valid", ts_ov, 1);
            chk("t5_s_out", ts_out, t_exp[c]);
        end
        t_valid = 1'b0;
        step();
        chk("t5_b_drain", tb_ov, 0);
        chk("t5_s_drain", ts_ov, 0);

        // random valid/ready stress, model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            in        = $urandom;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        chk("stress_drain", out_valid, 0);

        // 6: counter saturation over 70000 deliveries
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 70002; i++) begin
            in = $urandom;
            step();
        end
        chk("t6_cnt", xfer_cnt, cnt_exp);
        repeat (5) step();
        chk("t6_cnt_hold", xfer_cnt, cnt_exp);
        in_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
